// File: rtl/axi4_lite_arb2.sv
// Two-requester AXI4-Lite arbiter: independent write/read grant FSMs sharing one downstream slave.
// Define AXI4_LITE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default round-robin.
module axi4_lite_arb2 #(
  parameter int unsigned ADDR_BIT_WIDTH = 32,
  parameter int unsigned DATA_BIT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  // Upstream requester 0
  input  logic [ADDR_BIT_WIDTH-1:0]     mst0_awaddr_i,
  input  logic [2:0]                    mst0_awprot_i,
  input  logic                          mst0_awvalid_i,
  output logic                          mst0_awready_o,
  input  logic [DATA_BIT_WIDTH-1:0]     mst0_wdata_i,
  input  logic [DATA_BIT_WIDTH/8-1:0]   mst0_wstrb_i,
  input  logic                          mst0_wvalid_i,
  output logic                          mst0_wready_o,
  output logic [1:0]                    mst0_bresp_o,
  output logic                          mst0_bvalid_o,
  input  logic                          mst0_bready_i,
  input  logic [ADDR_BIT_WIDTH-1:0]     mst0_araddr_i,
  input  logic [2:0]                    mst0_arprot_i,
  input  logic                          mst0_arvalid_i,
  output logic                          mst0_arready_o,
  output logic [DATA_BIT_WIDTH-1:0]     mst0_rdata_o,
  output logic [1:0]                    mst0_rresp_o,
  output logic                          mst0_rvalid_o,
  input  logic                          mst0_rready_i,
  // Upstream requester 1
  input  logic [ADDR_BIT_WIDTH-1:0]     mst1_awaddr_i,
  input  logic [2:0]                    mst1_awprot_i,
  input  logic                          mst1_awvalid_i,
  output logic                          mst1_awready_o,
  input  logic [DATA_BIT_WIDTH-1:0]     mst1_wdata_i,
  input  logic [DATA_BIT_WIDTH/8-1:0]   mst1_wstrb_i,
  input  logic                          mst1_wvalid_i,
  output logic                          mst1_wready_o,
  output logic [1:0]                    mst1_bresp_o,
  output logic                          mst1_bvalid_o,
  input  logic                          mst1_bready_i,
  input  logic [ADDR_BIT_WIDTH-1:0]     mst1_araddr_i,
  input  logic [2:0]                    mst1_arprot_i,
  input  logic                          mst1_arvalid_i,
  output logic                          mst1_arready_o,
  output logic [DATA_BIT_WIDTH-1:0]     mst1_rdata_o,
  output logic [1:0]                    mst1_rresp_o,
  output logic                          mst1_rvalid_o,
  input  logic                          mst1_rready_i,
  // Downstream shared slave
  output logic [ADDR_BIT_WIDTH-1:0]     slv_awaddr_o,
  output logic [2:0]                    slv_awprot_o,
  output logic                          slv_awvalid_o,
  input  logic                          slv_awready_i,
  output logic [DATA_BIT_WIDTH-1:0]     slv_wdata_o,
  output logic [DATA_BIT_WIDTH/8-1:0]   slv_wstrb_o,
  output logic                          slv_wvalid_o,
  input  logic                          slv_wready_i,
  input  logic [1:0]                    slv_bresp_i,
  input  logic                          slv_bvalid_i,
  output logic                          slv_bready_o,
  output logic [ADDR_BIT_WIDTH-1:0]     slv_araddr_o,
  output logic [2:0]                    slv_arprot_o,
  output logic                          slv_arvalid_o,
  input  logic                          slv_arready_i,
  input  logic [DATA_BIT_WIDTH-1:0]     slv_rdata_i,
  input  logic [1:0]                    slv_rresp_i,
  input  logic                          slv_rvalid_i,
  output logic                          slv_rready_o
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} arb_state_e;

  arb_state_e wr_state_q, wr_state_d;
  arb_state_e rd_state_q, rd_state_d;

  logic wr_done, rd_done;
  logic prio_wr, prio_rd;

  // A grant ends on the downstream response handshake, as seen through the routed ready.
  assign wr_done = slv_bvalid_i & slv_bready_o;
  assign rd_done = slv_rvalid_i & slv_rready_o;

`ifdef AXI4_LITE_ARB_FIXED_PRIO_EN
  assign prio_wr = 1'b0;
  assign prio_rd = 1'b0;
`else
  logic prio_wr_q, prio_wr_d;
  logic prio_rd_q, prio_rd_d;

  assign prio_wr = prio_wr_q;
  assign prio_rd = prio_rd_q;

  // Completing requester hands preference to the other one.
  always_comb begin
    prio_wr_d = prio_wr_q;
    prio_rd_d = prio_rd_q;
    if (wr_done && (wr_state_q == StGnt0)) prio_wr_d = 1'b1;
    if (wr_done && (wr_state_q == StGnt1)) prio_wr_d = 1'b0;
    if (rd_done && (rd_state_q == StGnt0)) prio_rd_d = 1'b1;
    if (rd_done && (rd_state_q == StGnt1)) prio_rd_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      prio_wr_q <= 1'b0;
      prio_rd_q <= 1'b0;
    end else begin
      prio_wr_q <= prio_wr_d;
      prio_rd_q <= prio_rd_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_state_q <= StIdle;
      rd_state_q <= StIdle;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Write next state: only awvalid requests; wvalid alone is ignored.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      StIdle: begin
        if (mst0_awvalid_i && mst1_awvalid_i) begin
          wr_state_d = prio_wr ? StGnt1 : StGnt0;
        end else if (mst0_awvalid_i) begin
          wr_state_d = StGnt0;
        end else if (mst1_awvalid_i) begin
          wr_state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (wr_done) wr_state_d = StIdle;
      end
      default: wr_state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      StIdle: begin
        if (mst0_arvalid_i && mst1_arvalid_i) begin
          rd_state_d = prio_rd ? StGnt1 : StGnt0;
        end else if (mst0_arvalid_i) begin
          rd_state_d = StGnt0;
        end else if (mst1_arvalid_i) begin
          rd_state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (rd_done) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  // Write routing: everything zero unless a requester holds the write grant.
  always_comb begin
    slv_awaddr_o   = '0;
    slv_awprot_o   = '0;
    slv_awvalid_o  = 1'b0;
    slv_wdata_o    = '0;
    slv_wstrb_o    = '0;
    slv_wvalid_o   = 1'b0;
    slv_bready_o   = 1'b0;
    mst0_awready_o = 1'b0;
    mst0_wready_o  = 1'b0;
    mst0_bresp_o   = '0;
    mst0_bvalid_o  = 1'b0;
    mst1_awready_o = 1'b0;
    mst1_wready_o  = 1'b0;
    mst1_bresp_o   = '0;
    mst1_bvalid_o  = 1'b0;
    unique case (wr_state_q)
      StGnt0: begin
        slv_awaddr_o   = mst0_awaddr_i;
        slv_awprot_o   = mst0_awprot_i;
        slv_awvalid_o  = mst0_awvalid_i;
        slv_wdata_o    = mst0_wdata_i;
        slv_wstrb_o    = mst0_wstrb_i;
        slv_wvalid_o   = mst0_wvalid_i;
        slv_bready_o   = mst0_bready_i;
        mst0_awready_o = slv_awready_i;
        mst0_wready_o  = slv_wready_i;
        mst0_bresp_o   = slv_bresp_i;
        mst0_bvalid_o  = slv_bvalid_i;
      end
      StGnt1: begin
        slv_awaddr_o   = mst1_awaddr_i;
        slv_awprot_o   = mst1_awprot_i;
        slv_awvalid_o  = mst1_awvalid_i;
        slv_wdata_o    = mst1_wdata_i;
        slv_wstrb_o    = mst1_wstrb_i;
        slv_wvalid_o   = mst1_wvalid_i;
        slv_bready_o   = mst1_bready_i;
        mst1_awready_o = slv_awready_i;
        mst1_wready_o  = slv_wready_i;
        mst1_bresp_o   = slv_bresp_i;
        mst1_bvalid_o  = slv_bvalid_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    slv_araddr_o   = '0;
    slv_arprot_o   = '0;
    slv_arvalid_o  = 1'b0;
    slv_rready_o   = 1'b0;
    mst0_arready_o = 1'b0;
    mst0_rdata_o   = '0;
    mst0_rresp_o   = '0;
    mst0_rvalid_o  = 1'b0;
    mst1_arready_o = 1'b0;
    mst1_rdata_o   = '0;
    mst1_rresp_o   = '0;
    mst1_rvalid_o  = 1'b0;
    unique case (rd_state_q)
      StGnt0: begin
        slv_araddr_o   = mst0_araddr_i;
        slv_arprot_o   = mst0_arprot_i;
        slv_arvalid_o  = mst0_arvalid_i;
        slv_rready_o   = mst0_rready_i;
        mst0_arready_o = slv_arready_i;
        mst0_rdata_o   = slv_rdata_i;
        mst0_rresp_o   = slv_rresp_i;
        mst0_rvalid_o  = slv_rvalid_i;
      end
      StGnt1: begin
        slv_araddr_o   = mst1_araddr_i;
        slv_arprot_o   = mst1_arprot_i;
        slv_arvalid_o  = mst1_arvalid_i;
        slv_rready_o   = mst1_rready_i;
        mst1_arready_o = slv_arready_i;
        mst1_rdata_o   = slv_rdata_i;
        mst1_rresp_o   = slv_rresp_i;
        mst1_rvalid_o  = slv_rvalid_i;
      end
      default: ;
    endcase
  end

endmodule
